tt_sweep: RTL and testbench

Parametrised, self-checking exhaustive stimulus engine for small combinational blocks under test. On `start` it walks every input vector 0 … 2^N_IN−1 and holds each one for SETTLE cycles. At the end of each hold it samples the block's response and compares it against a parameter-supplied expected truth table, with a per-vector don't-care mask. It streams one log record per vector, replacing per-step monitor prints, and reports an error count, the first failing index and pass/fail. It sits between the bench or an on-chip test controller and the block under test.

---
 rtl/tt_sweep_pkg.sv | 27 ++
 rtl/tt_sweep_if.sv | 33 +++
 rtl/tt_sweep_cmp.sv | 17 +
 rtl/tt_sweep.sv | 150 +++++++++++++++
 tb/tb_tt_sweep.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared state type and truth-table helpers for the sweep engine
package tt_sweep_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest truth table / response slice the helper below can address.
    localparam int TBL_MAX = 1024;
    localparam int OUT_MAX = 32;

    // Number of vectors in a sweep over an n_in-bit stimulus.
    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

    // Returns slice [idx*n_out +: n_out] of a packed table, zero-extended to OUT_MAX.
    function automatic logic [OUT_MAX-1:0] tbl_slice(input logic [TBL_MAX-1:0] tbl,
                                                     input int idx,
                                                     input int n_out);
        logic [OUT_MAX-1:0] mask;
        mask = ~({OUT_MAX{1'b1}} << n_out);
        return OUT_MAX'(tbl >> (idx * n_out)) & mask;
    endfunction

endpackage

// File: rtl/tt_sweep_if.sv
// rtl/tt_sweep_if.sv - control, stimulus/response and log bundle of the sweep engine
// master: test controller plus block under test (drives start, abort, resp)
// slave : sweep engine (drives stim, status and log record)
interface tt_sweep_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1
);
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  stim;
    logic [N_OUT-1:0] resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN:0]    err_count;
    logic [N_IN-1:0]  first_err_idx;
    logic             log_valid;
    logic [N_IN-1:0]  log_idx;
    logic [N_OUT-1:0] log_resp;
    logic             log_err;

    modport master (
        output start, abort, resp,
        input  stim, busy, done, pass, err_count, first_err_idx,
               log_valid, log_idx, log_resp, log_err
    );

    modport slave (
        input  start, abort, resp,
        output stim, busy, done, pass, err_count, first_err_idx,
               log_valid, log_idx, log_resp, log_err
    );
endinterface

// File: rtl/tt_sweep_cmp.sv
// rtl/tt_sweep_cmp.sv - masked response comparator
// resp_i : sampled response
// exp_i  : expected response
// care_i : 1 = bit is compared, 0 = don't-care
// mism_o : any cared bit differs
module tt_sweep_cmp #(
    parameter int N_OUT = 1
) (
    input  logic [N_OUT-1:0] resp_i,
    input  logic [N_OUT-1:0] exp_i,
    input  logic [N_OUT-1:0] care_i,
    output logic             mism_o
);

    assign mism_o = |((resp_i ^ exp_i) & care_i);

endmodule

// File: rtl/tt_sweep.sv
// rtl/tt_sweep.sv - exhaustive truth-table sweep engine for small combinational blocks
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : slave side of tt_sweep_if (start/abort in, stim out, resp in,
//         busy/done/pass/err_count/first_err_idx status, one log record per vector)
module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int                          N_IN     = 2,
    parameter int                          N_OUT    = 1,
    parameter int                          SETTLE   = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0]  EXPECTED = 4'b1000,
    parameter logic [N_OUT*(2**N_IN)-1:0]  CARE     = '1
) (
    input  logic        clk,
    input  logic        rst_n,
    tt_sweep_if.slave   bus
);

    localparam int                 N_VEC    = vec_count(N_IN);
    localparam int                 CNT_W    = $clog2(SETTLE + 1);
    localparam logic [N_IN-1:0]    LAST_IDX = N_IN'(N_VEC - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [TBL_MAX-1:0] EXP_TBL  = TBL_MAX'(EXPECTED);
    localparam logic [TBL_MAX-1:0] CARE_TBL = TBL_MAX'(CARE);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              lv_q, lv_d;
    logic [N_IN-1:0]   lidx_q, lidx_d;
    logic [N_OUT-1:0]  lresp_q, lresp_d;
    logic              lerr_q, lerr_d;

    logic [N_OUT-1:0]  exp_w;
    logic [N_OUT-1:0]  care_w;
    logic              mism;

    // Table lookup for the vector currently on stim; resp arrives combinationally.
    assign exp_w  = N_OUT'(tbl_slice(EXP_TBL, int'(stim_q), N_OUT));
    assign care_w = N_OUT'(tbl_slice(CARE_TBL, int'(stim_q), N_OUT));

    tt_sweep_cmp #(.N_OUT(N_OUT)) u_cmp (
        .resp_i (bus.resp),
        .exp_i  (exp_w),
        .care_i (care_w),
        .mism_o (mism)
    );

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        lv_d    = 1'b0;
        lidx_d  = lidx_q;
        lresp_d = lresp_q;
        lerr_d  = lerr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    stim_d  = '0;
                    cnt_d   = CNT_LOAD;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                // Abort wins over a coincident sample edge: no record, no done.
                if (bus.abort) begin
                    state_d = IDLE;
                    stim_d  = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    lv_d    = 1'b1;
                    lidx_d  = stim_q;
                    lresp_d = bus.resp;
                    lerr_d  = mism;
                    if (mism) begin
                        err_d = err_q + (N_IN+1)'(1);
                        if (err_q == '0) begin
                            first_d = stim_q;
                        end
                    end
                    if (stim_q != LAST_IDX) begin
                        stim_d = stim_q + N_IN'(1);
                        cnt_d  = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        stim_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            lv_q    <= 1'b0;
            lidx_q  <= '0;
            lresp_q <= '0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            lv_q    <= lv_d;
            lidx_q  <= lidx_d;
            lresp_q <= lresp_d;
            lerr_q  <= lerr_d;
        end
    end

    assign bus.stim          = stim_q;
    assign bus.busy          = (state_q == RUN);
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_q;
    assign bus.log_valid     = lv_q;
    assign bus.log_idx       = lidx_q;
    assign bus.log_resp      = lresp_q;
    assign bus.log_err       = lerr_q;

endmodule

// File: tb/tb_tt_sweep.sv
// tb/tb_tt_sweep.sv - directed and randomized bench for tt_sweep against a behavioural model
module tb_tt_sweep;

    localparam int NG = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 start_v [NG];
    logic                 abort_v [NG];
    logic [NG-1:0]        busy_v;
    logic [NG-1:0]        done_v;
    logic [NG-1:0][3:0]   stim_v;
    int                   n_chk = 0;
    int                   n_fail = 0;
    int                   cyc = 0;

    // Instance configurations: 0 AND/pass, 1 AND vs XOR table, 2 XOR table with
    // care on vector 0 only, 3 popcount width scaling, 4 random block table.
    function automatic int cfg_nin(input int g);
        case (g)
            3:       return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_nout(input int g);
        return (g >= 3) ? 2 : 1;
    endfunction

    function automatic int cfg_settle(input int g);
        case (g)
            3:       return 1;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [63:0] cfg_exp(input int g);
        case (g)
            0:       return 64'h8;
            3:       return 64'h3EE9_E994;
            4:       return 64'hA5C;
            default: return 64'h6;
        endcase
    endfunction

    function automatic logic [63:0] cfg_care(input int g);
        case (g)
            2:       return 64'h1;
            4:       return 64'hF3B;
            default: return '1;
        endcase
    endfunction

    task automatic chk(input string nm, input int g, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got %0d, expected %0d at cycle %0d", nm, g, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    for (genvar g = 0; g < NG; g++) begin : u
        localparam int NI = cfg_nin(g);
        localparam int NO = cfg_nout(g);
        localparam int S  = cfg_settle(g);
        localparam int NV = 1 << NI;
        localparam int W  = NO * NV;
        localparam logic [W-1:0] EXP = W'(cfg_exp(g));
        localparam logic [W-1:0] CRE = W'(cfg_care(g));

        tt_sweep_if #(.N_IN(NI), .N_OUT(NO)) ifc ();

        tt_sweep #(
            .N_IN(NI), .N_OUT(NO), .SETTLE(S), .EXPECTED(EXP), .CARE(CRE)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );

        logic [NO-1:0] rtab [NV];
        int etab [NV];
        int ctab [NV];

        // Block under test.
        function automatic logic [NO-1:0] blk(input int v);
            if (g == 3) return NO'($countones(v & 15));
            if (g == 4) return rtab[v[NI-1:0]];
            return NO'((v & (v >> 1)) & 1);
        endfunction

        assign ifc.start = start_v[g];
        assign ifc.abort = abort_v[g];
        assign ifc.resp  = blk(int'(ifc.stim));
        assign busy_v[g] = ifc.busy;
        assign done_v[g] = ifc.done;
        assign stim_v[g] = 4'(ifc.stim);

        // Model: sweep position is the cycle count k since the accepted start.
        bit run = 0, mpass = 0, mdone = 0, mlv = 0, me = 0;
        int k = 0, errs = 0, first = 0, mi = 0, mr = 0, midx = 0, mresp = 0, merr = 0;
        int ndone = 0, lat = 0, t0 = 0;
        bit busy_prev = 0;
        int lq[$], eq[$], iq[$];

        initial begin
            for (int i = 0; i < NV; i++) begin
                etab[i] = int'(EXP >> (i * NO)) & ((1 << NO) - 1);
                ctab[i] = int'(CRE >> (i * NO)) & ((1 << NO) - 1);
                rtab[i] = NO'($urandom);
            end
        end

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                run = 0; k = 0; errs = 0; first = 0; mpass = 0; mdone = 0; mlv = 0;
            end else begin
                mdone = 0;
                mlv = 0;
                if (run) begin
                    if (abort_v[g]) begin
                        run = 0;
                    end else begin
                        k++;
                        if (k % S == 0) begin
                            mi = k / S - 1;
                            mr = int'(blk(mi));
                            me = ((mr ^ etab[mi]) & ctab[mi]) != 0;
                            mlv = 1; midx = mi; mresp = mr; merr = int'(me);
                            if (me) begin
                                if (errs == 0) first = mi;
                                errs++;
                            end
                            if (mi == NV - 1) begin
                                run = 0; mdone = 1; mpass = (errs == 0);
                            end
                        end
                    end
                end else if (start_v[g]) begin
                    run = 1; k = 0; errs = 0; first = 0; mpass = 0;
                    if (g == 4) for (int i = 0; i < NV; i++) rtab[i] = NO'($urandom);
                end
            end
        end

        initial forever begin
            @(negedge clk);
            chk("busy", g, ifc.busy, run);
            chk("stim", g, ifc.stim, run ? k / S : 0);
            chk("done", g, ifc.done, mdone);
            chk("pass", g, ifc.pass, mpass);
            chk("err_count", g, ifc.err_count, errs);
            chk("first_err_idx", g, ifc.first_err_idx, first);
            chk("log_valid", g, ifc.log_valid, mlv);
            if (mlv) begin
                chk("log_idx", g, ifc.log_idx, midx);
                chk("log_resp", g, ifc.log_resp, mresp);
                chk("log_err", g, ifc.log_err, merr);
            end
            if (ifc.log_valid) begin
                lq.push_back(int'(ifc.log_resp));
                eq.push_back(int'(ifc.log_err));
                iq.push_back(int'(ifc.log_idx));
            end
            if (ifc.busy && !busy_prev) t0 = cyc;
            if (ifc.done) begin
                ndone++;
                lat = cyc - t0;
            end
            busy_prev = ifc.busy;
        end
    end

    task automatic pulse_start(input logic [NG-1:0] m);
        for (int g = 0; g < NG; g++) start_v[g] = m[g];
        @(negedge clk);
        for (int g = 0; g < NG; g++) start_v[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (busy_v[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", g, busy_v[g], 0);
    endtask

    task automatic wait_stim(input int g, input int v, input int budget);
        int n = 0;
        while (int'(stim_v[g]) != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_stim", g, stim_v[g], v);
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!done_v[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", g, done_v[g], 1);
    endtask

    task automatic zero0(input string tag);
        chk({tag, "_busy"}, 0, u[0].ifc.busy, 0);
        chk({tag, "_stim"}, 0, u[0].ifc.stim, 0);
        chk({tag, "_done"}, 0, u[0].ifc.done, 0);
        chk({tag, "_pass"}, 0, u[0].ifc.pass, 0);
        chk({tag, "_err_count"}, 0, u[0].ifc.err_count, 0);
        chk({tag, "_first_err_idx"}, 0, u[0].ifc.first_err_idx, 0);
        chk({tag, "_log_valid"}, 0, u[0].ifc.log_valid, 0);
        chk({tag, "_log_idx"}, 0, u[0].ifc.log_idx, 0);
        chk({tag, "_log_resp"}, 0, u[0].ifc.log_resp, 0);
        chk({tag, "_log_err"}, 0, u[0].ifc.log_err, 0);
    endtask

    initial begin
        int b, n0;
        rst_n = 1'b0;
        for (int g = 0; g < NG; g++) begin
            start_v[g] = 1'b0;
            abort_v[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        zero0("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Truth-table cases and width scaling, all started together.
        pulse_start(5'b01111);
        wait_idle(3, 40);
        for (int g = 0; g < 3; g++) chk("sweep_idle", g, busy_v[g], 0);
        chk("and_nlog", 0, u[0].lq.size(), 4);
        chk("and_resp0", 0, u[0].lq[0], 0);
        chk("and_resp1", 0, u[0].lq[1], 0);
        chk("and_resp2", 0, u[0].lq[2], 0);
        chk("and_resp3", 0, u[0].lq[3], 1);
        chk("and_latency", 0, u[0].lat, 8);
        chk("and_err_count", 0, u[0].ifc.err_count, 0);
        chk("and_pass", 0, u[0].ifc.pass, 1);
        chk("model_and_pass", 0, u[0].mpass, 1);
        chk("xor_err0", 1, u[1].eq[0], 0);
        chk("xor_err1", 1, u[1].eq[1], 1);
        chk("xor_err2", 1, u[1].eq[2], 1);
        chk("xor_err3", 1, u[1].eq[3], 1);
        chk("xor_err_count", 1, u[1].ifc.err_count, 3);
        chk("xor_first_err_idx", 1, u[1].ifc.first_err_idx, 1);
        chk("xor_pass", 1, u[1].ifc.pass, 0);
        chk("model_xor_err", 1, u[1].errs, 3);
        chk("model_xor_first", 1, u[1].first, 1);
        chk("care_err_count", 2, u[2].ifc.err_count, 0);
        chk("care_pass", 2, u[2].ifc.pass, 1);
        chk("pop_nlog", 3, u[3].lq.size(), 16);
        chk("pop_latency", 3, u[3].lat, 16);
        chk("pop_err_count", 3, u[3].ifc.err_count, 0);
        chk("pop_pass", 3, u[3].ifc.pass, 1);

        // Abort while vector 2 is driven, then a clean sweep.
        b = u[0].lq.size();
        n0 = u[0].ndone;
        pulse_start(5'b00001);
        wait_stim(0, 2, 20);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("abort_busy", 0, busy_v[0], 0);
        chk("abort_stim", 0, stim_v[0], 0);
        chk("abort_no_done", 0, u[0].ndone, n0);
        chk("abort_nlog", 0, u[0].lq.size() - b, 2);
        pulse_start(5'b00001);
        wait_idle(0, 20);
        chk("after_abort_done", 0, u[0].ndone, n0 + 1);
        chk("after_abort_nlog", 0, u[0].lq.size() - b, 6);
        chk("after_abort_pass", 0, u[0].ifc.pass, 1);

        // Asynchronous reset while vector 1 is driven.
        n0 = u[0].ndone;
        pulse_start(5'b00001);
        wait_stim(0, 1, 20);
        #1 rst_n = 1'b0;
        #1 zero0("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_done", 0, u[0].ndone, n0);

        // Start while busy is ignored.
        b = u[0].iq.size();
        n0 = u[0].ndone;
        pulse_start(5'b00001);
        repeat (2) @(negedge clk);
        pulse_start(5'b00001);
        wait_idle(0, 20);
        chk("busy_start_nlog", 0, u[0].iq.size() - b, 4);
        for (int i = 0; i < 4; i++) chk("busy_start_idx", 0, u[0].iq[b + i], i);
        chk("busy_start_latency", 0, u[0].lat, 8);
        repeat (2) @(negedge clk);
        chk("busy_start_no_restart", 0, busy_v[0], 0);
        chk("busy_start_done", 0, u[0].ndone, n0 + 1);

        // Start in the done cycle begins a new sweep at once.
        n0 = u[0].ndone;
        pulse_start(5'b00001);
        wait_done(0, 20);
        pulse_start(5'b00001);
        chk("restart_busy", 0, busy_v[0], 1);
        chk("restart_stim", 0, stim_v[0], 0);
        wait_idle(0, 20);
        chk("restart_done", 0, u[0].ndone, n0 + 2);
        chk("restart_latency", 0, u[0].lat, 8);

        // Random start/abort/reset traffic on all instances.
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NG; g++) begin
                start_v[g] = ($urandom_range(0, 3) == 0);
                abort_v[g] = ($urandom_range(0, 29) == 0);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        for (int g = 0; g < NG; g++) begin
            start_v[g] = 1'b0;
            abort_v[g] = 1'b0;
        end
        repeat (40) @(negedge clk);
        for (int g = 0; g < NG; g++) chk("final_idle", g, busy_v[g], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
